// File: rtl/data_sram_ctrl.sv
// Multi-cycle bridge from the core data-memory port to a single-port synchronous SRAM
// with fixed read latency; stalls the pipeline until each access completes.
module data_sram_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [3:0]        sel_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              stallreq_o,
    output logic              sram_ce_o,
    output logic              sram_we_o,
    output logic [ADDR_W-3:0] sram_addr_o,
    output logic [3:0]        sram_be_o,
    output logic [31:0]       sram_wdata_o,
    input  logic [31:0]       sram_rdata_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic        live;
    logic        req_we;
    logic [31:0] rdata;

    // Byte offset bits are meaningless to a word-wide SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ce_i) next_state = ACCESS;
            ACCESS:  if (cnt == 4'd0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The registered sram_* outputs double as the latched request: they are loaded
    // on acceptance, so they are valid from the first ACCESS cycle and stay stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= 4'd0;
            live         <= 1'b0;
            req_we       <= 1'b0;
            rdata        <= 32'd0;
            sram_ce_o    <= 1'b0;
            sram_we_o    <= 1'b0;
            sram_addr_o  <= '0;
            sram_be_o    <= 4'd0;
            sram_wdata_o <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (ce_i) begin
                        req_we       <= we_i;
                        cnt          <= 4'(WAIT_CYCLES);
                        live         <= 1'b1;
                        sram_ce_o    <= 1'b1;
                        sram_we_o    <= we_i;
                        sram_addr_o  <= addr_i[ADDR_W-1:2];
                        sram_be_o    <= sel_i;
                        sram_wdata_o <= data_i;
                    end
                end
                ACCESS: begin
                    sram_we_o <= 1'b0;
                    if (!ce_i) begin
                        live <= 1'b0;
                    end
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!req_we) begin
                            rdata <= sram_rdata_i;
                        end
                        sram_ce_o    <= 1'b0;
                        sram_addr_o  <= '0;
                        sram_be_o    <= 4'd0;
                        sram_wdata_o <= 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // A flushed access (live cleared) neither releases the stall nor returns data.
    assign stallreq_o = ce_i & ~((state == DONE) & live);
    assign data_o     = ((state == DONE) && live && !req_we) ? rdata : 32'd0;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: one instance with WAIT_CYCLES=2 and one with
// WAIT_CYCLES=0, sharing clock and reset.
module tb_data_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        ce_a = 1'b0, we_a = 1'b0;
    logic [31:0] addr_a = 32'd0, wdata_in_a = 32'd0;
    logic [3:0]  sel_a = 4'd0;
    logic [31:0] data_a, sram_wdata_a;
    logic        stall_a, sram_ce_a, sram_we_a;
    logic [29:0] sram_addr_a;
    logic [3:0]  sram_be_a;
    logic [31:0] sram_rdata_a = 32'hDEADBEEF;

    logic        ce_b = 1'b0;
    logic [31:0] addr_b = 32'd0;
    logic [31:0] data_b, sram_wdata_b, sram_rdata_b;
    logic        stall_b, sram_ce_b, sram_we_b;
    logic [29:0] sram_addr_b;
    logic [3:0]  sram_be_b;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    // Instance B reads from a combinational pattern memory keyed on word address.
    assign sram_rdata_b = {sram_addr_b, 2'b00} ^ 32'hCAFE0000;

    data_sram_ctrl #(.ADDR_W(32), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .ce_i(ce_a), .we_i(we_a), .addr_i(addr_a),
        .sel_i(sel_a), .data_i(wdata_in_a), .data_o(data_a), .stallreq_o(stall_a),
        .sram_ce_o(sram_ce_a), .sram_we_o(sram_we_a), .sram_addr_o(sram_addr_a),
        .sram_be_o(sram_be_a), .sram_wdata_o(sram_wdata_a), .sram_rdata_i(sram_rdata_a)
    );

    data_sram_ctrl #(.ADDR_W(32), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .ce_i(ce_b), .we_i(1'b0), .addr_i(addr_b),
        .sel_i(4'hF), .data_i(32'd0), .data_o(data_b), .stallreq_o(stall_b),
        .sram_ce_o(sram_ce_b), .sram_we_o(sram_we_b), .sram_addr_o(sram_addr_b),
        .sram_be_o(sram_be_b), .sram_wdata_o(sram_wdata_b), .sram_rdata_i(sram_rdata_b)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ce, input logic we, input logic [31:0] addr,
                                 input logic [3:0] sel, input logic [31:0] data);
        ce_a       = ce;
        we_a       = we;
        addr_a     = addr;
        sel_a      = sel;
        wdata_in_a = data;
    endtask

    // Called at a negedge; runs one full load on instance A and checks stall length,
    // SRAM word address and that data appears only in the final (DONE) cycle.
    task automatic runLoadA(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_data);
        int cycles = 0;
        int early = 0;
        logic [29:0] addr_seen = '0;
        applyStimulus(1'b1, 1'b0, addr, 4'hF, 32'd0);
        #1;
        while (stall_a && cycles < 20) begin
            if (cycles == 1) addr_seen = sram_addr_a;
            if (data_a != 32'd0) early++;
            cycles++;
            @(negedge clk);
            #1;
        end
        checkOutput({tag, "_stall_cycles"}, cycles, 32'd4);
        checkOutput({tag, "_sram_addr"}, {2'b00, addr_seen}, {2'b00, addr[31:2]});
        checkOutput({tag, "_early_data"}, early, 32'd0);
        checkOutput({tag, "_done_data"}, data_a, exp_data);
        applyStimulus(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        @(negedge clk);
        #1;
        checkOutput({tag, "_idle_data"}, data_a, 32'd0);
    endtask

    initial begin
        logic        exp_stall_b [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        exp_ce_b    [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp_data_b  [6] = '{32'd0, 32'd0, 32'hCAFE0040,
                                         32'd0, 32'd0, 32'hCAFE0080};

        // Reset held with a pending request.
        applyStimulus(1'b1, 1'b0, 32'h104, 4'hF, 32'd0);
        #2;
        checkOutput("rst_stall", stall_a, 1'b1);
        checkOutput("rst_sram_ce", sram_ce_a, 1'b0);
        checkOutput("rst_data", data_a, 32'd0);
        checkOutput("rst_b_sram_ce", sram_ce_b, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post_rst_stall", stall_a, 1'b0);
        checkOutput("post_rst_sram_ce", sram_ce_a, 1'b0);

        // Basic load.
        @(negedge clk);
        runLoadA("load", 32'h104, 32'hDEADBEEF);

        // Store: single write pulse on the first ACCESS cycle.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'h200, 4'b0011, 32'h12345678);
        #1;
        checkOutput("st_idle_stall", stall_a, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("st_we_%0d", i), sram_we_a, (i == 0) ? 1'b1 : 1'b0);
            checkOutput($sformatf("st_ce_%0d", i), sram_ce_a, 1'b1);
            checkOutput($sformatf("st_be_%0d", i), sram_be_a, 4'b0011);
            checkOutput($sformatf("st_wdata_%0d", i), sram_wdata_a, 32'h12345678);
            checkOutput($sformatf("st_addr_%0d", i), sram_addr_a, 30'h80);
        end
        @(negedge clk);
        #1;
        checkOutput("st_done_stall", stall_a, 1'b0);
        checkOutput("st_done_data", data_a, 32'd0);
        checkOutput("st_done_ce", sram_ce_a, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);

        // Flush in the second ACCESS cycle, then re-request during DONE.
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h108, 4'hF, 32'd0);
        #1;
        checkOutput("fl_idle_stall", stall_a, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("fl_acc1_ce", sram_ce_a, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 32'h108, 4'hF, 32'd0);
        #1;
        checkOutput("fl_acc2_stall", stall_a, 1'b0);
        checkOutput("fl_acc2_ce", sram_ce_a, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("fl_acc3_ce", sram_ce_a, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h10C, 4'hF, 32'd0);
        #1;
        checkOutput("fl_done_stall", stall_a, 1'b1);
        checkOutput("fl_done_data", data_a, 32'd0);
        checkOutput("fl_done_ce", sram_ce_a, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("fl_idle2_stall", stall_a, 1'b1);
        checkOutput("fl_idle2_ce", sram_ce_a, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("fl_new_ce", sram_ce_a, 1'b1);
        checkOutput("fl_new_addr", sram_addr_a, 30'h43);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("fl_new_stall", stall_a, 1'b0);
        checkOutput("fl_new_data", data_a, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);

        // Asynchronous reset in the middle of a store.
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, 32'h300, 4'hF, 32'hAAAA5555);
        @(negedge clk);
        #1;
        checkOutput("ar_we_before", sram_we_a, 1'b1);
        checkOutput("ar_ce_before", sram_ce_a, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("ar_ce_after", sram_ce_a, 1'b0);
        checkOutput("ar_we_after", sram_we_a, 1'b0);
        checkOutput("ar_stall", stall_a, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        runLoadA("post_ar", 32'h104, 32'hDEADBEEF);

        // WAIT_CYCLES=0: back-to-back loads, 3-cycle spacing.
        @(negedge clk);
        ce_b   = 1'b1;
        addr_b = 32'h40;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            checkOutput($sformatf("b2b_stall_%0d", cyc), stall_b, exp_stall_b[cyc]);
            checkOutput($sformatf("b2b_ce_%0d", cyc), sram_ce_b, exp_ce_b[cyc]);
            checkOutput($sformatf("b2b_data_%0d", cyc), data_b, exp_data_b[cyc]);
            if (cyc == 2) addr_b = 32'h80;
            if (cyc == 5) ce_b = 1'b0;
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
